// File: rtl/alpha_trigger_gen.sv
// Trigger conditioner for the alpha sequencer: synchronises and debounces a raw level input,
// then emits one single-cycle pulse on every accepted rising transition.
module alpha_trigger_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  output logic a,
  output logic a_level
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRiseChk = 2'd1,
    StPressed = 2'd2,
    StFallChk = 2'd3
  } state_e;

  // The entering edge already counts as the first stable sample, hence the -1.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser; only s2_q is seen by the qualification logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= a_raw;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a       <= 1'b0;
      a_level <= 1'b0;
    end else begin
      a <= 1'b0;
      case (state_q)
        StIdle: begin
          if (s2_q) begin
            state_q <= StRiseChk;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        StRiseChk: begin
          if (!s2_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StPressed;
            cnt_q   <= '0;
            a       <= 1'b1;
            a_level <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!s2_q) begin
            state_q <= StFallChk;
            cnt_q   <= CntOne;
          end
        end
        StFallChk: begin
          // A return to 1 here is release bounce: back to PRESSED with no new pulse.
          if (s2_q) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_level <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          a_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_trigger_gen.sv
// Bench for alpha_trigger_gen: default instance plus a DEBOUNCE_CYCLES=2 instance, both checked
// each cycle against a run-length model of the debounced level.
module tb_alpha_trigger_gen;

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic a4, lvl4, a2, lvl2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: synchroniser pipe plus, per instance, accepted level and run of disagreeing samples.
  bit m_s1, m_s2;
  bit m_lvl4, m_p4, m_lvl2, m_p2;
  int run4, run2;

  alpha_trigger_gen dut4 (
    .clk     (clk),
    .rst     (rst),
    .a_raw   (a_raw),
    .a       (a4),
    .a_level (lvl4)
  );

  alpha_trigger_gen #(
    .DEBOUNCE_CYCLES (2),
    .CNT_W           (2)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .a_raw   (a_raw),
    .a       (a2),
    .a_level (lvl2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0;
    m_lvl4 = 0; m_p4 = 0; run4 = 0;
    m_lvl2 = 0; m_p2 = 0; run2 = 0;
  endtask

  task automatic adv(input int d, input bit s2, inout bit lvl, inout int run, output bit p);
    p = 0;
    if (s2 != lvl) begin
      run++;
      if (run == d) begin
        lvl = s2;
        run = 0;
        p   = s2;
      end
    end else begin
      run = 0;
    end
  endtask

  // Drive one input sample, advance one clock, leave time at the following falling edge.
  task automatic tick(input logic v);
    a_raw = v;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      adv(4, m_s2, m_lvl4, run4, m_p4);
      adv(2, m_s2, m_lvl2, run2, m_p2);
      m_s2 = m_s1;
      m_s1 = a_raw;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int pk4, pk2;
    rst = 1'b1;
    model_reset();
    repeat (3) tick(1'b0);
    n_checks++;
    if ({a4, lvl4, a2, lvl2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: outputs got %b want 0000", {a4, lvl4, a2, lvl2});
    end
    rst = 1'b0;
    repeat (3) tick(1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1);
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL reset_press t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (lvl4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pressed_level: a_level got %b want 1", lvl4);
    end
    // Asynchronous assertion mid-cycle with a_raw still high.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({a4, lvl4, a2, lvl2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: outputs got %b want 0000", {a4, lvl4, a2, lvl2});
    end
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;
    pk4 = 0;
    pk2 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1);
      if (a4 === 1'b1 && pk4 == 0) pk4 = k;
      if (a2 === 1'b1 && pk2 == 0) pk2 = k;
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL reset_rehold t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (pk4 != 6) begin
      n_fail++;
      $display("FAIL reset_rehold_latency: pulse at sample %0d want 6", pk4);
    end
    n_checks++;
    if (pk2 != 4) begin
      n_fail++;
      $display("FAIL reset_rehold_latency_d2: pulse at sample %0d want 4", pk2);
    end
    repeat (10) tick(1'b0);
  endtask

  task automatic test_clean_press();
    int pk, npulse, nhigh, nrel;
    pk = 0; npulse = 0; nhigh = 0; nrel = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(k <= 20);
      if (a4 === 1'b1) begin
        npulse++;
        if (pk == 0) pk = k;
        if (k > 20) nrel++;
      end
      if (lvl4 === 1'b1) nhigh++;
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL clean_press t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (npulse != 1 || pk != 6) begin
      n_fail++;
      $display("FAIL clean_press_pulse: %0d pulses first at %0d want 1 at 6", npulse, pk);
    end
    n_checks++;
    if (nhigh != 20) begin
      n_fail++;
      $display("FAIL clean_press_level: high for %0d cycles want 20", nhigh);
    end
    n_checks++;
    if (nrel != 0) begin
      n_fail++;
      $display("FAIL clean_press_release: %0d release pulses want 0", nrel);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] train;
    int early, npulse, at13;
    train = 7'b0111011;  // LSB first: 1,1,0,1,1,1,0
    early = 0; npulse = 0; at13 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(k <= 7 ? train[k-1] : (k <= 20));
      if (a4 === 1'b1) begin
        npulse++;
        if (k < 13) early++;
        if (k == 13) at13 = 1;
      end
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL bounce t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (early != 0 || npulse != 1 || at13 != 1) begin
      n_fail++;
      $display("FAIL bounce_pulses: early=%0d total=%0d at13=%0d want 0 1 1", early, npulse, at13);
    end
  endtask

  task automatic test_release_bounce();
    int npulse, nlow;
    npulse = 0; nlow = 0;
    for (int k = 1; k <= 32; k++) begin
      tick(k <= 10 || (k >= 13 && k <= 22));
      if (k <= 22 && a4 === 1'b1) npulse++;
      if (k >= 6 && k <= 22 && lvl4 !== 1'b1) nlow++;
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL release_bounce t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (npulse != 1 || nlow != 0) begin
      n_fail++;
      $display("FAIL release_bounce_hold: pulses=%0d low_cycles=%0d want 1 0", npulse, nlow);
    end
  endtask

  task automatic test_back_to_back();
    int t, np, first, second;
    t = 0; np = 0; first = 0; second = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(k <= 24 && ((k - 1) % 12) < 6);
      if (a4 === 1'b1) begin
        np++;
        if (np == 1) first = k;
        if (np == 2) second = k;
      end
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL back_to_back t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    t = second - first;
    n_checks++;
    if (np != 2 || t < 9) begin
      n_fail++;
      $display("FAIL back_to_back_pulses: %0d pulses spacing %0d want 2 and >=9", np, t);
    end
  endtask

  task automatic test_random();
    logic v;
    int len;
    for (int s = 0; s < 60; s++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        tick(v);
        n_checks++;
        if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
          n_fail++;
          $display("FAIL random t=%0t: outputs got %b want %b", $time,
                   {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
        end
      end
    end
    repeat (10) tick(1'b0);
  endtask

  task automatic test_param_sweep();
    int glitch, pk, over;
    glitch = 0; pk = 0; over = 0;
    for (int k = 1; k <= 21; k++) begin
      tick(k == 1 || (k >= 8 && k <= 15));
      if (k < 8 && (a2 === 1'b1 || lvl2 === 1'b1)) glitch++;
      if (k >= 8 && a2 === 1'b1 && pk == 0) pk = k - 7;
      if (dut2.cnt_q > 2'd1) over++;
      n_checks++;
      if ({a4, lvl4, a2, lvl2} !== {m_p4, m_lvl4, m_p2, m_lvl2}) begin
        n_fail++;
        $display("FAIL param_sweep t=%0t: outputs got %b want %b", $time,
                 {a4, lvl4, a2, lvl2}, {m_p4, m_lvl4, m_p2, m_lvl2});
      end
    end
    n_checks++;
    if (glitch != 0) begin
      n_fail++;
      $display("FAIL param_sweep_glitch: %0d glitch responses want 0", glitch);
    end
    n_checks++;
    if (pk != 4) begin
      n_fail++;
      $display("FAIL param_sweep_latency: pulse at sample %0d want 4", pk);
    end
    n_checks++;
    if (over != 0) begin
      n_fail++;
      $display("FAIL param_sweep_cnt: counter above 1 in %0d cycles want 0", over);
    end
  endtask

  initial begin
    rst   = 1'b1;
    a_raw = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_back_to_back();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
